// File: rtl/fetch_pkg.sv
// Shared FSM encoding, base-register widths and parameter defaults for the wavefront fetch scheduler.
package fetch_pkg;

  localparam int DEF_NUM_WF     = 40;
  localparam int DEF_PC_W       = 32;
  localparam int DEF_TAG_W      = 15;
  localparam int DEF_LINE_BYTES = 32;

  localparam int VGPR_BASE_W = 10;
  localparam int SGPR_BASE_W = 9;
  localparam int LDS_BASE_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant starting after the last granted index.
// The pointer moves to the granted index only when upd is asserted with a valid grant.
module fetch_rr_arb
  import fetch_pkg::*;
#(
  parameter int N = DEF_NUM_WF,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             upd,
  output logic             gnt_vld,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;

  function automatic logic [IDX_W-1:0] wrap(input int a);
    int r;
    r = (a >= N) ? a - N : a;
    return IDX_W'(r);
  endfunction

  // Scan from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[wrap(int'(ptr) + k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap(int'(ptr) + k);
      end
    end
    gnt = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDX_W'(N - 1);
    end else if (upd && gnt_vld) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/wf_fetch_sched.sv
// Wavefront slot table plus a single-outstanding, round-robin instruction fetch scheduler.
// Request issues the cycle after REQ and holds until buff_ack; FETCH_PERF_CNT_EN adds perf counters.
module wf_fetch_sched
  import fetch_pkg::*;
#(
  parameter int NUM_WF     = DEF_NUM_WF,
  parameter int PC_W       = DEF_PC_W,
  parameter int TAG_W      = DEF_TAG_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  localparam int WFID_W    = $clog2(NUM_WF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch2cu_wf_dispatch,
  input  logic [TAG_W-1:0]       dispatch2cu_wf_tag_dispatch,
  input  logic [PC_W-1:0]        dispatch2cu_start_pc_dispatch,
  input  logic [VGPR_BASE_W-1:0] dispatch2cu_vgpr_base_dispatch,
  input  logic [SGPR_BASE_W-1:0] dispatch2cu_sgpr_base_dispatch,
  input  logic [LDS_BASE_W-1:0]  dispatch2cu_lds_base_dispatch,
  input  logic                   buff_ack,
  input  logic [NUM_WF-1:0]      wave_stop_fetch,
  input  logic                   issue_wf_done_en,
  input  logic [WFID_W-1:0]      issue_wf_done_wf_id,
  input  logic                   salu_branch_en,
  input  logic [WFID_W-1:0]      salu_branch_wfid,
  input  logic                   salu_branch_taken,
  input  logic [PC_W-1:0]        salu_branch_pc_value,
  output logic                   buff_rd_en,
  output logic [PC_W-1:0]        buff_addr,
  output logic [WFID_W+PC_W-1:0] buff_tag,
  output logic                   wave_basereg_wr,
  output logic [WFID_W-1:0]      wave_basereg_wfid,
  output logic [VGPR_BASE_W-1:0] wave_vgpr_base,
  output logic [SGPR_BASE_W-1:0] wave_sgpr_base,
  output logic [LDS_BASE_W-1:0]  wave_lds_base,
  output logic                   cu2dispatch_wf_done,
  output logic [TAG_W-1:0]       cu2dispatch_wf_tag_done,
  output logic                   fetch_full
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_stall_cnt
`endif
);

  localparam logic [PC_W-1:0] LINE_MASK = ~PC_W'(LINE_BYTES - 1);
  localparam logic [PC_W-1:0] LINE_INC  = PC_W'(LINE_BYTES);

  fetch_state_t      state;
  logic [NUM_WF-1:0] wf_vld;
  logic [TAG_W-1:0]  wf_tag [NUM_WF];
  logic [PC_W-1:0]   wf_pc  [NUM_WF];
  logic [WFID_W-1:0] gnt_id;
  logic              gnt_stale;

  logic [NUM_WF-1:0] done_hit, br_hit, elig_vld, arb_gnt;
  logic [WFID_W-1:0] alloc_id, arb_idx;
  logic [TAG_W-1:0]  done_tag;
  logic [PC_W-1:0]   arb_pc;
  logic              done_vld, alloc_vld, disp_vld, arb_vld, br_on_arb, ack_adv;

  // Slot-indexed strobes only hit valid slots, which also filters out-of-range ids.
  always_comb begin
    done_hit = '0;
    br_hit   = '0;
    done_tag = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      done_hit[i] = issue_wf_done_en && wf_vld[i] && (issue_wf_done_wf_id == WFID_W'(i));
      br_hit[i]   = salu_branch_en && wf_vld[i] && (salu_branch_wfid == WFID_W'(i));
      if (done_hit[i]) done_tag = wf_tag[i];
    end
  end

  always_comb begin
    alloc_vld = 1'b0;
    alloc_id  = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (!wf_vld[i]) begin
        alloc_vld = 1'b1;
        alloc_id  = WFID_W'(i);
      end
    end
  end

  always_comb begin
    arb_pc = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      if (arb_gnt[i]) arb_pc = wf_pc[i];
    end
  end

  assign fetch_full = &wf_vld;
  assign done_vld   = |done_hit;
  assign disp_vld   = dispatch2cu_wf_dispatch && alloc_vld;
  assign elig_vld   = wf_vld & ~wave_stop_fetch & ~done_hit;
  assign br_on_arb  = salu_branch_taken && |(br_hit & arb_gnt);
  // A branch or retire on the outstanding slot in the ack cycle overrides the advance.
  assign ack_adv    = (state == ST_WAIT) && buff_ack && !gnt_stale &&
                      !br_hit[gnt_id] && !done_hit[gnt_id];

  fetch_rr_arb #(.N(NUM_WF)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (elig_vld),
    .upd     (state == ST_REQ),
    .gnt_vld (arb_vld),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= ST_IDLE;
      wf_vld                  <= '0;
      gnt_id                  <= '0;
      gnt_stale               <= 1'b0;
      buff_rd_en              <= 1'b0;
      buff_addr               <= '0;
      buff_tag                <= '0;
      wave_basereg_wr         <= 1'b0;
      wave_basereg_wfid       <= '0;
      wave_vgpr_base          <= '0;
      wave_sgpr_base          <= '0;
      wave_lds_base           <= '0;
      cu2dispatch_wf_done     <= 1'b0;
      cu2dispatch_wf_tag_done <= '0;
      for (int i = 0; i < NUM_WF; i++) begin
        wf_tag[i] <= '0;
        wf_pc[i]  <= '0;
      end
    end else begin
      buff_rd_en          <= 1'b0;
      wave_basereg_wr     <= disp_vld;
      cu2dispatch_wf_done <= done_vld;
      if (disp_vld) begin
        wave_basereg_wfid <= alloc_id;
        wave_vgpr_base    <= dispatch2cu_vgpr_base_dispatch;
        wave_sgpr_base    <= dispatch2cu_sgpr_base_dispatch;
        wave_lds_base     <= dispatch2cu_lds_base_dispatch;
      end
      if (done_vld) cu2dispatch_wf_tag_done <= done_tag;

      for (int i = 0; i < NUM_WF; i++) begin
        if (disp_vld && alloc_id == WFID_W'(i)) begin
          wf_vld[i] <= 1'b1;
          wf_tag[i] <= dispatch2cu_wf_tag_dispatch;
          wf_pc[i]  <= dispatch2cu_start_pc_dispatch;
        end else begin
          if (done_hit[i]) wf_vld[i] <= 1'b0;
          if (br_hit[i] && salu_branch_taken) wf_pc[i] <= salu_branch_pc_value;
          else if (ack_adv && gnt_id == WFID_W'(i)) wf_pc[i] <= buff_addr + LINE_INC;
        end
      end

      case (state)
        ST_IDLE: if (|elig_vld) state <= ST_REQ;
        ST_REQ: begin
          if (arb_vld) begin
            buff_rd_en <= 1'b1;
            buff_addr  <= arb_pc & LINE_MASK;
            buff_tag   <= {arb_idx, arb_pc};
            gnt_id     <= arb_idx;
            gnt_stale  <= br_on_arb;
            state      <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (buff_ack) state <= ST_IDLE;
          else if ((br_hit[gnt_id] && salu_branch_taken) || done_hit[gnt_id]) gnt_stale <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (buff_rd_en && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == ST_WAIT && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wf_fetch_sched.sv
// Directed cycle-table bench for wf_fetch_sched with four slots and 32-byte lines.
module tb_wf_fetch_sched;

  localparam int NUM_WF = 4;
  localparam int PC_W   = 32;
  localparam int TAG_W  = 15;
  localparam int WFID_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   dispatch2cu_wf_dispatch;
  logic [TAG_W-1:0]       dispatch2cu_wf_tag_dispatch;
  logic [PC_W-1:0]        dispatch2cu_start_pc_dispatch;
  logic [9:0]             dispatch2cu_vgpr_base_dispatch;
  logic [8:0]             dispatch2cu_sgpr_base_dispatch;
  logic [15:0]            dispatch2cu_lds_base_dispatch;
  logic                   buff_ack;
  logic [NUM_WF-1:0]      wave_stop_fetch;
  logic                   issue_wf_done_en;
  logic [WFID_W-1:0]      issue_wf_done_wf_id;
  logic                   salu_branch_en;
  logic [WFID_W-1:0]      salu_branch_wfid;
  logic                   salu_branch_taken;
  logic [PC_W-1:0]        salu_branch_pc_value;
  logic                   buff_rd_en;
  logic [PC_W-1:0]        buff_addr;
  logic [WFID_W+PC_W-1:0] buff_tag;
  logic                   wave_basereg_wr;
  logic [WFID_W-1:0]      wave_basereg_wfid;
  logic [9:0]             wave_vgpr_base;
  logic [8:0]             wave_sgpr_base;
  logic [15:0]            wave_lds_base;
  logic                   cu2dispatch_wf_done;
  logic [TAG_W-1:0]       cu2dispatch_wf_tag_done;
  logic                   fetch_full;

  wf_fetch_sched #(.NUM_WF(NUM_WF), .PC_W(PC_W), .TAG_W(TAG_W), .LINE_BYTES(32)) dut (
    .clk(clk), .rst(rst),
    .dispatch2cu_wf_dispatch(dispatch2cu_wf_dispatch),
    .dispatch2cu_wf_tag_dispatch(dispatch2cu_wf_tag_dispatch),
    .dispatch2cu_start_pc_dispatch(dispatch2cu_start_pc_dispatch),
    .dispatch2cu_vgpr_base_dispatch(dispatch2cu_vgpr_base_dispatch),
    .dispatch2cu_sgpr_base_dispatch(dispatch2cu_sgpr_base_dispatch),
    .dispatch2cu_lds_base_dispatch(dispatch2cu_lds_base_dispatch),
    .buff_ack(buff_ack), .wave_stop_fetch(wave_stop_fetch),
    .issue_wf_done_en(issue_wf_done_en), .issue_wf_done_wf_id(issue_wf_done_wf_id),
    .salu_branch_en(salu_branch_en), .salu_branch_wfid(salu_branch_wfid),
    .salu_branch_taken(salu_branch_taken), .salu_branch_pc_value(salu_branch_pc_value),
    .buff_rd_en(buff_rd_en), .buff_addr(buff_addr), .buff_tag(buff_tag),
    .wave_basereg_wr(wave_basereg_wr), .wave_basereg_wfid(wave_basereg_wfid),
    .wave_vgpr_base(wave_vgpr_base), .wave_sgpr_base(wave_sgpr_base), .wave_lds_base(wave_lds_base),
    .cu2dispatch_wf_done(cu2dispatch_wf_done), .cu2dispatch_wf_tag_done(cu2dispatch_wf_tag_done),
    .fetch_full(fetch_full)
  );

  typedef struct packed {
    logic        rst;
    logic        disp;
    logic [14:0] dtag;
    logic [31:0] dpc;
    logic [34:0] dbases;
    logic        ack;
    logic [3:0]  stop;
    logic        den;
    logic [1:0]  did;
    logic        ben;
    logic [1:0]  bid;
    logic        btk;
    logic [31:0] bpc;
    logic        e_rd;
    logic [31:0] e_addr;
    logic [33:0] e_btag;
    logic        e_bwr;
    logic [1:0]  e_wfid;
    logic [34:0] e_bases;
    logic        e_done;
    logic [14:0] e_dtag;
    logic        e_full;
    logic        e_zero;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t nop();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic logic [34:0] bs(input int vg, input int sg, input int ld);
    return {10'(vg), 9'(sg), 16'(ld)};
  endfunction

  function automatic vec_t v_dsp(input vec_t b, input logic [14:0] t, input logic [31:0] pc,
                                 input logic [34:0] bases, input logic [1:0] slot);
    vec_t v = b;
    v.disp = 1'b1; v.dtag = t; v.dpc = pc; v.dbases = bases;
    v.e_bwr = 1'b1; v.e_wfid = slot; v.e_bases = bases;
    return v;
  endfunction

  function automatic vec_t v_fch(input vec_t b, input logic [1:0] slot, input logic [31:0] pc);
    vec_t v = b;
    v.e_rd = 1'b1; v.e_addr = pc & 32'hFFFF_FFE0; v.e_btag = {slot, pc};
    return v;
  endfunction

  function automatic vec_t v_ack(input vec_t b);
    vec_t v = b;
    v.ack = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_brn(input vec_t b, input logic [1:0] slot, input logic tk, input logic [31:0] pc);
    vec_t v = b;
    v.ben = 1'b1; v.bid = slot; v.btk = tk; v.bpc = pc;
    return v;
  endfunction

  function automatic vec_t v_ret(input vec_t b, input logic [1:0] slot, input logic [14:0] tag);
    vec_t v = b;
    v.den = 1'b1; v.did = slot; v.e_done = 1'b1; v.e_dtag = tag;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst                            = v.rst;
    dispatch2cu_wf_dispatch        = v.disp;
    dispatch2cu_wf_tag_dispatch    = v.dtag;
    dispatch2cu_start_pc_dispatch  = v.dpc;
    dispatch2cu_vgpr_base_dispatch = v.dbases[34:25];
    dispatch2cu_sgpr_base_dispatch = v.dbases[24:16];
    dispatch2cu_lds_base_dispatch  = v.dbases[15:0];
    buff_ack                       = v.ack;
    wave_stop_fetch                = v.stop;
    issue_wf_done_en               = v.den;
    issue_wf_done_wf_id            = v.did;
    salu_branch_en                 = v.ben;
    salu_branch_wfid               = v.bid;
    salu_branch_taken              = v.btk;
    salu_branch_pc_value           = v.bpc;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {6'd0, buff_rd_en, buff_addr, buff_tag, wave_basereg_wr, wave_basereg_wfid,
            wave_vgpr_base, wave_sgpr_base, wave_lds_base, cu2dispatch_wf_done,
            cu2dispatch_wf_tag_done, fetch_full};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit   seen;

    // Vector table: inputs applied before each edge, outputs expected after it.
    vt.push_back(v_dsp(nop(), 15'd5, 32'd18, bs(9, 10, 20), 2'd0));       // 0
    vt.push_back(nop());                                                 // 1
    vt.push_back(v_fch(nop(), 2'd0, 32'd18));                            // 2
    vt.push_back(v_ack(nop()));                                          // 3
    vt.push_back(v_dsp(nop(), 15'd7, 32'h100, bs(1, 2, 3), 2'd1));       // 4
    vt.push_back(v_fch(nop(), 2'd1, 32'h100));                           // 5
    vt.push_back(v_ack(nop()));                                          // 6
    vt.push_back(nop());                                                 // 7
    vt.push_back(v_fch(nop(), 2'd0, 32'h20));                            // 8
    vt.push_back(v_ack(nop()));                                          // 9
    vt.push_back(nop());                                                 // 10
    vt.push_back(v_fch(nop(), 2'd1, 32'h120));                           // 11
    vt.push_back(v_ack(nop()));                                          // 12
    vt.push_back(nop());                                                 // 13
    vt.push_back(v_fch(nop(), 2'd0, 32'h40));                            // 14
    vt.push_back(v_brn(nop(), 2'd0, 1'b1, 32'h30));                      // 15
    v = v_ack(nop()); v.stop = 4'b0010; vt.push_back(v);                 // 16
    v = nop(); v.stop = 4'b0010; vt.push_back(v);                        // 17
    v = v_fch(nop(), 2'd0, 32'h30); v.stop = 4'b0010; vt.push_back(v);   // 18
    vt.push_back(v_brn(v_ack(nop()), 2'd0, 1'b1, 32'h200));              // 19
    vt.push_back(nop());                                                 // 20
    vt.push_back(v_fch(nop(), 2'd1, 32'h140));                           // 21
    vt.push_back(v_ack(nop()));                                          // 22
    vt.push_back(nop());                                                 // 23
    vt.push_back(v_fch(nop(), 2'd0, 32'h200));                           // 24
    vt.push_back(v_ack(nop()));                                          // 25
    vt.push_back(v_ret(v_dsp(nop(), 15'd9, 32'h400, bs(4, 5, 6), 2'd2), 2'd1, 15'd7)); // 26
    vt.push_back(v_fch(nop(), 2'd2, 32'h400));                           // 27
    vt.push_back(v_ack(nop()));                                          // 28
    vt.push_back(v_dsp(nop(), 15'd10, 32'h500, bs(1, 1, 1), 2'd1));     // 29
    v = v_dsp(v_fch(nop(), 2'd0, 32'h220), 15'd11, 32'h600, bs(2, 2, 2), 2'd3); v.e_full = 1'b1; vt.push_back(v); // 30
    v = nop(); v.disp = 1'b1; v.dtag = 15'd12; v.dpc = 32'h800; v.dbases = bs(3, 3, 3); v.e_full = 1'b1; vt.push_back(v); // 31
    vt.push_back(v_ret(nop(), 2'd0, 15'd5));                             // 32
    vt.push_back(v_ack(nop()));                                          // 33
    v = v_dsp(nop(), 15'd13, 32'h700, bs(5, 5, 5), 2'd0); v.e_full = 1'b1; vt.push_back(v); // 34
    v = v_fch(nop(), 2'd1, 32'h500); v.e_full = 1'b1; vt.push_back(v);   // 35
    v = nop(); v.rst = 1'b1; v.e_zero = 1'b1; vt.push_back(v);           // 36
    vt.push_back(nop());                                                 // 37
    vt.push_back(nop());                                                 // 38
    vt.push_back(nop());                                                 // 39
    vt.push_back(v_dsp(nop(), 15'd1, 32'h40, bs(6, 7, 8), 2'd0));        // 40
    vt.push_back(nop());                                                 // 41
    vt.push_back(v_fch(nop(), 2'd0, 32'h40));                            // 42

    v = nop(); v.rst = 1'b1;
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 128'd0);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i]);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d rd_en", i), buff_rd_en, vt[i].e_rd);
      if (vt[i].e_rd) begin
        chk($sformatf("row%0d buff_addr", i), buff_addr, vt[i].e_addr);
        chk($sformatf("row%0d buff_tag", i), buff_tag, vt[i].e_btag);
      end
      chk($sformatf("row%0d basereg_wr", i), wave_basereg_wr, vt[i].e_bwr);
      if (vt[i].e_bwr) begin
        chk($sformatf("row%0d basereg_wfid", i), wave_basereg_wfid, vt[i].e_wfid);
        chk($sformatf("row%0d bases", i), {wave_vgpr_base, wave_sgpr_base, wave_lds_base}, vt[i].e_bases);
      end
      chk($sformatf("row%0d wf_done", i), cu2dispatch_wf_done, vt[i].e_done);
      if (vt[i].e_done) chk($sformatf("row%0d wf_tag_done", i), cu2dispatch_wf_tag_done, vt[i].e_dtag);
      chk($sformatf("row%0d fetch_full", i), fetch_full, vt[i].e_full);
      if (vt[i].e_zero) chk($sformatf("row%0d all_zero", i), all_outs(), 128'd0);
    end

    // Slot 0 is outstanding at 0x40: not-taken branch must not block the advance,
    // and a retire on an empty slot must produce no done pulse.
    @(negedge clk);
    drive(v_brn(v_ret(nop(), 2'd2, 15'd0), 2'd0, 1'b0, 32'h999));
    @(posedge clk);
    #1;
    chk("retire_invalid_done", cu2dispatch_wf_done, 1'b0);
    @(negedge clk);
    drive(v_ack(nop()));
    @(negedge clk);
    drive(nop());
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (buff_rd_en) seen = 1'b1;
    end
    chk("nottaken_refetch_seen", seen, 1'b1);
    if (seen) begin
      chk("nottaken_refetch_addr", buff_addr, 32'h60);
      chk("nottaken_refetch_tag", buff_tag, {2'd0, 32'h60});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
